dot_product_stream: RTL and testbench

// - Streaming dot-product engine: accepts element pairs (a_i, b_i) over a valid/ready input, multiplies and

---
 rtl/dot_product_stream.sv | 176 +++++++++++++++++
 tb/tb_dot_product_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_stream.sv
// dot_product_stream: streaming unsigned dot-product engine.
// Accepts VEC_LEN (a, b) pairs over a valid/ready input, multiplies each pair
// into a product register, accumulates at full precision, then presents the
// sum over a valid/ready output and holds it until it is taken.
// Optional feature macro: DOT_PRODUCT_SAT_EN -- when defined, results wider
// than OUT_WIDTH clamp to all ones; otherwise they wrap (low OUT_WIDTH bits).
// ovf flags an oversized result in both builds.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the first pair of a vector, in_ready high
// ACCUM  | collecting the remaining pairs, in_ready high
// DRAIN  | two edges: last product add, then result register load
// HOLD   | result presented, waiting for out_ready

module dot_product_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 4,
  parameter int OUT_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  resetn_tb,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int FULL_W = 2 * DATA_WIDTH + $clog2(VEC_LEN);
  localparam int CNT_W  = $clog2(VEC_LEN);
  localparam int EXT_W  = (FULL_W > OUT_WIDTH) ? FULL_W : OUT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic                  prod_vld_q, prod_vld_d;
  logic [FULL_W-1:0]     acc_q, acc_d;
  logic                  drain_q, drain_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  ovf_q, ovf_d;
  // Holds in_ready low during reset and only enables it one edge after release.
  logic                  rdy_en_q, rdy_en_d;

  logic                  xfer;
  logic                  last_elem;
  logic                  out_xfer;
  logic [EXT_W-1:0]      acc_ext;
  logic                  too_big;
  logic [OUT_WIDTH-1:0]  result;

  assign xfer      = in_valid & in_ready;
  assign last_elem = (cnt_q == CNT_W'(VEC_LEN - 1));
  assign out_xfer  = (state_q == S_HOLD) & out_valid_q & out_ready;

  // Widen the accumulator so the overflow test and truncation work for any
  // relation between FULL_W and OUT_WIDTH.
  always_comb begin
    acc_ext = EXT_W'(acc_q);
    too_big = ((acc_ext >> OUT_WIDTH) != '0);
`ifdef DOT_PRODUCT_SAT_EN
    result  = too_big ? '1 : acc_ext[OUT_WIDTH-1:0];
`else
    result  = acc_ext[OUT_WIDTH-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge resetn_tb) begin
    if (!resetn_tb) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (xfer) state_d = S_ACCUM;
      S_ACCUM: if (xfer && last_elem) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_HOLD;
      S_HOLD:  if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  // FSM-decoded outputs.
  always_comb begin
    in_ready = rdy_en_q & ((state_q == S_IDLE) | (state_q == S_ACCUM));
    busy     = (state_q != S_IDLE);
  end

  // Datapath next values: product pipeline, accumulator, result register.
  always_comb begin
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    acc_d       = acc_q;
    drain_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    rdy_en_d    = 1'b1;
    if (clr) begin
      cnt_d       = '0;
      prod_d      = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      ovf_d       = 1'b0;
    end else begin
      if (xfer) begin
        prod_d     = PROD_W'(in_a) * PROD_W'(in_b);
        prod_vld_d = 1'b1;
        cnt_d      = last_elem ? '0 : cnt_q + CNT_W'(1);
      end
      if (prod_vld_q) acc_d = acc_q + FULL_W'(prod_q);
      if (state_q == S_DRAIN) begin
        drain_d = ~drain_q;
        if (drain_q) begin
          out_valid_d = 1'b1;
          out_data_d  = result;
          ovf_d       = ovf_q | too_big;
        end
      end
      if (out_xfer) begin
        out_valid_d = 1'b0;
        acc_d       = '0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn_tb) begin
    if (!resetn_tb) begin
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      drain_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench for dot_product_stream: default instance (OUT_WIDTH=18) plus
// a narrow instance (OUT_WIDTH=16) fed the same stimulus for overflow checks.

module tb_dot_product_stream;

  logic        clk = 1'b0;
  logic        resetn_tb = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, busy, ovf;
  logic [17:0] out_data;
  logic        in_ready16, out_valid16, busy16, ovf16;
  logic [15:0] out_data16;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dot_product_stream #(.DATA_WIDTH(8), .VEC_LEN(4), .OUT_WIDTH(18)) dut (
    .clk(clk), .resetn_tb(resetn_tb), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ovf(ovf)
  );

  dot_product_stream #(.DATA_WIDTH(8), .VEC_LEN(4), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .resetn_tb(resetn_tb), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .busy(busy16), .ovf(ovf16)
  );

  // Offer one pair starting at a negedge; returns at the negedge after transfer.
  task automatic xfer(input logic [7:0] a, input logic [7:0] b, output bit ok);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_a = 8'hA5;
    in_b = 8'h5A;
  endtask

  task automatic test_reset();
    resetn_tb = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, busy, ovf, out_data} !== 22'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b ovf=%b data=%0d, want all 0",
               in_ready, out_valid, busy, ovf, out_data);
    end
    @(negedge clk);
    resetn_tb = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_release_rdy: got %b want 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] bv [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer(av[i], bv[i], ok);
      n_cmp++;
      if (!ok) begin n_mis++; $display("FAIL basic_xfer%0d: got timeout want transfer", i); end
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_mis++; $display("FAIL basic_lat0: got v=%b want 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_mis++; $display("FAIL basic_lat1: got v=%b want 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'h00046 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL basic_result: got v=%b data=%h ovf=%b rdy=%b want 1 00046 0 0",
               out_valid, out_data, ovf, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL basic_single_cycle: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_max_operands();
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) xfer(8'd255, 8'd255, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'h3F804 || ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL max18: got v=%b data=%h ovf=%b want 1 3f804 0", out_valid, out_data, ovf);
    end
    n_cmp++;
`ifdef DOT_PRODUCT_SAT_EN
    if (out_valid16 !== 1'b1 || out_data16 !== 16'hFFFF || ovf16 !== 1'b1) begin
      n_mis++;
      $display("FAIL max16_sat: got v=%b data=%h ovf=%b want 1 ffff 1", out_valid16, out_data16, ovf16);
    end
`else
    if (out_valid16 !== 1'b1 || out_data16 !== 16'hF804 || ovf16 !== 1'b1) begin
      n_mis++;
      $display("FAIL max16_wrap: got v=%b data=%h ovf=%b want 1 f804 1", out_valid16, out_data16, ovf16);
    end
`endif
    @(negedge clk);
    n_cmp++;
    if (ovf16 !== 1'b1) begin n_mis++; $display("FAIL ovf_sticky: got %b want 1", ovf16); end
  endtask

  task automatic test_gaps_backpressure();
    bit ok;
    logic [7:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] bv [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    int gap [4] = '{1, 3, 2, 0};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(av[i], bv[i], ok);
      repeat (gap[i]) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 18'd70 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_mis++;
        $display("FAIL hold_cycle%0d: got v=%b data=%0d rdy=%b busy=%b want 1 70 0 1",
                 c, out_valid, out_data, in_ready, busy);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL hold_release: got v=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_clr();
    bit ok;
    out_ready = 1'b1;
    xfer(8'd9, 8'd9, ok);
    xfer(8'd9, 8'd9, ok);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || ovf !== 1'b0 || ovf16 !== 1'b0) begin
      n_mis++;
      $display("FAIL clr_idle: got busy=%b v=%b ovf=%b ovf16=%b want 0 0 0 0", busy, out_valid, ovf, ovf16);
    end
    for (int i = 0; i < 4; i++) xfer(8'd1, 8'd2, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'd8) begin
      n_mis++;
      $display("FAIL clr_next_vec: got v=%b data=%0d want 1 8", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] bv [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    out_ready = 1'b1;
    xfer(8'd200, 8'd200, ok);
    xfer(8'd200, 8'd200, ok);
    resetn_tb = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, ovf, out_data} !== 22'd0) begin
      n_mis++;
      $display("FAIL reset_mid_vec: got rdy=%b v=%b busy=%b ovf=%b data=%0d want all 0",
               in_ready, out_valid, busy, ovf, out_data);
    end
    @(negedge clk);
    resetn_tb = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) xfer(8'd255, 8'd255, ok);
    repeat (3) @(negedge clk);
    resetn_tb = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, ovf, out_data} !== 22'd0 || ovf16 !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_in_hold: got rdy=%b v=%b busy=%b ovf=%b ovf16=%b data=%0d want all 0",
               in_ready, out_valid, busy, ovf, ovf16, out_data);
    end
    @(negedge clk);
    resetn_tb = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) xfer(av[i], bv[i], ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'd70 || ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL post_reset_vec: got v=%b data=%0d ovf=%b want 1 70 0", out_valid, out_data, ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_gaps_backpressure();
    test_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
